// File: rtl/swipt_pkg.sv
// Shared types for the SWIPT receive-side period meter.
package swipt_pkg;

    localparam int CNT_W_DEF = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } meas_state_e;

endpackage

// File: rtl/swipt_period_meter_if.sv
// Result handshake between the period meter and the controller.
interface swipt_period_meter_if
    import swipt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    modport master (
        output meas_valid,
        output period,
        output high_time,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  period,
        input  high_time,
        output meas_ready
    );
endinterface

// File: rtl/swipt_edge_filter.sv
// Synchronizes the comparator, rejects pulses shorter than FILT_LEN samples and
// emits one-cycle rise/fall pulses on each accepted level change.
module swipt_edge_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic nrst,
    input  logic comp_i,
    output logic rise_o,
    output logic fall_o
);
    localparam int RUN_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // run_q counts consecutive samples that disagree with the accepted level
    always_comb begin
        level_d = level_q;
        run_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (run_q == RUN_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            run_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= comp_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/swipt_period_meter.sv
// Measures period and high time of the returning comparator waveform, averages
// 2^AVG_LG periods and offers each result over a valid/ready handshake.
module swipt_period_meter
    import swipt_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter int               FILT_LEN = 3,
    parameter int               AVG_LG   = 2,
    parameter logic [CNT_W-1:0] TIMEOUT  = {CNT_W{1'b1}}
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        en,
    input  logic                        comp_in,
    swipt_period_meter_if.master        mif,
    output logic                        timeout,
    output logic                        overrun
);
    localparam int ACC_W  = CNT_W + AVG_LG;
    localparam int NPER_W = AVG_LG + 1;
    localparam logic [NPER_W-1:0] NPER_FULL = NPER_W'(1 << AVG_LG);

    logic rise, fall;

    swipt_edge_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk    (clk),
        .nrst   (nrst),
        .comp_i (comp_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    meas_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  pacc_q, pacc_d;
    logic [ACC_W-1:0]  hacc_q, hacc_d;
    logic [NPER_W-1:0] nper_q, nper_d;
    logic              fall_seen_q, fall_seen_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    logic              new_result;
    logic [ACC_W-1:0]  pacc_sum;
    logic [NPER_W-1:0] nper_inc;
    logic [CNT_W-1:0]  cnt_inc;

    assign pacc_sum = pacc_q + ACC_W'(cnt_q);
    assign nper_inc = nper_q + NPER_W'(1);
    assign cnt_inc  = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pacc_d      = pacc_q;
        hacc_d      = hacc_q;
        nper_d      = nper_q;
        fall_seen_d = fall_seen_q;
        valid_d     = valid_q;
        period_d    = period_q;
        high_d      = high_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;
        new_result  = 1'b0;

        if (valid_q && mif.meas_ready)
            valid_d = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        cnt_d       = CNT_W'(1);
                        pacc_d      = '0;
                        hacc_d      = '0;
                        nper_d      = '0;
                        fall_seen_d = 1'b0;
                        state_d     = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (cnt_q == TIMEOUT) begin
                        // Signal lost: drop the partial average and wait for a fresh edge
                        timeout_d = 1'b1;
                        pacc_d    = '0;
                        hacc_d    = '0;
                        nper_d    = '0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_inc;
                        if (fall && !fall_seen_q) begin
                            hacc_d      = hacc_q + ACC_W'(cnt_q);
                            fall_seen_d = 1'b1;
                        end
                        if (rise) begin
                            cnt_d       = CNT_W'(1);
                            fall_seen_d = 1'b0;
                            if (nper_inc == NPER_FULL) begin
                                new_result = 1'b1;
                                pacc_d     = '0;
                                hacc_d     = '0;
                                nper_d     = '0;
                            end else begin
                                pacc_d = pacc_sum;
                                nper_d = nper_inc;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (new_result) begin
            period_d  = CNT_W'(pacc_sum >> AVG_LG);
            high_d    = CNT_W'(hacc_q >> AVG_LG);
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            // A result accepted in this same cycle is not lost, so no overrun then
            if (valid_q && !mif.meas_ready)
                overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pacc_q      <= '0;
            hacc_q      <= '0;
            nper_q      <= '0;
            fall_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pacc_q      <= pacc_d;
            hacc_q      <= hacc_d;
            nper_q      <= nper_d;
            fall_seen_q <= fall_seen_d;
            valid_q     <= valid_d;
            period_q    <= period_d;
            high_q      <= high_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mif.meas_valid = valid_q;
    assign mif.period     = period_q;
    assign mif.high_time  = high_q;
    assign timeout        = timeout_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_swipt_period_meter.sv
// Randomized scoreboard bench for swipt_period_meter: expected averages come from
// the list of driven periods; a monitor compares each accepted result.
module tb_swipt_period_meter;
    localparam int CNT_W  = 20;
    localparam int AVG_LG = 2;
    localparam int NAVG   = 1 << AVG_LG;
    localparam int TMO    = 3000;

    typedef struct {
        longint per;
        longint hi;
    } exp_t;

    logic clk = 1'b0;
    logic nrst, en, comp, ready, tmo, ovr;
    int   chk = 0;
    int   errs = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    swipt_period_meter_if #(.CNT_W(CNT_W)) mif ();
    assign mif.meas_ready = ready;

    swipt_period_meter #(
        .CNT_W    (CNT_W),
        .FILT_LEN (3),
        .AVG_LG   (AVG_LG),
        .TIMEOUT  (CNT_W'(TMO))
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .en      (en),
        .comp_in (comp),
        .mif     (mif.master),
        .timeout (tmo),
        .overrun (ovr)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t avg(input int ps[$], input int hs[$], input int base);
        exp_t e;
        longint sp = 0, sh = 0;
        for (int k = 0; k < NAVG; k++) begin
            sp += ps[base+k];
            sh += hs[base+k];
        end
        e.per = sp / NAVG;
        e.hi  = sh / NAVG;
        return e;
    endfunction

    // One period starting with a rising edge; optional 2-cycle glitches mid-high and mid-low
    task automatic drive_per(input int p, input int h, input bit gl);
        comp = 1'b1;
        if (gl) begin
            cyc(h / 2); comp = 1'b0; cyc(2); comp = 1'b1; cyc(h - h / 2 - 2);
        end else cyc(h);
        comp = 1'b0;
        if (gl) begin
            cyc((p - h) / 2); comp = 1'b1; cyc(2); comp = 1'b0; cyc(p - h - (p - h) / 2 - 2);
        end else cyc(p - h);
    endtask

    task automatic run_seq(input int ps[$], input int hs[$], input bit gl);
        for (int j = 0; j < ps.size(); j++) begin
            if (j > 0 && j % NAVG == 0) exp_q.push_back(avg(ps, hs, j - NAVG));
            drive_per(ps[j], hs[j], gl);
        end
        exp_q.push_back(avg(ps, hs, ps.size() - NAVG));
        comp = 1'b1;
        cyc(12);
    endtask

    task automatic rand_seq(input int n, input int pmin, input int pmax, input int hmin,
                            output int ps[$], output int hs[$]);
        ps = {};
        hs = {};
        for (int j = 0; j < n; j++) begin
            int p;
            p = int'($urandom_range(pmax, pmin));
            ps.push_back(p);
            hs.push_back(int'($urandom_range(p - 10, hmin)));
        end
    endtask

    task automatic start_meas();
        en = 1'b1;
        cyc(4);
    endtask

    task automatic stop_meas();
        en = 1'b0;
        cyc(2);
        comp = 1'b0;
        cyc(12);
    endtask

    always @(negedge clk) begin
        if (!nrst && mif.meas_valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("period", mif.period, e.per);
                check("high_time", mif.high_time, e.hi);
                check("timeout_on_result", tmo, 0);
            end
        end
    end

    initial begin
        int ps[$], hs[$];
        exp_t eb, ec;
        nrst = 1'b1; en = 1'b0; comp = 1'b0; ready = 1'b1;
        cyc(3);
        check("rst_valid", mif.meas_valid, 0);
        check("rst_period", mif.period, 0);
        check("rst_high", mif.high_time, 0);
        check("rst_timeout", tmo, 0);
        check("rst_overrun", ovr, 0);
        nrst = 1'b0;
        cyc(5);

        // Nominal square wave
        start_meas();
        run_seq('{2624, 2624, 2624, 2624}, '{1312, 1312, 1312, 1312}, 1'b0);
        stop_meas();
        check("t1_overrun", ovr, 0);

        // Jittered periods: average truncates
        start_meas();
        run_seq('{2624, 2625, 2626, 2627}, '{1312, 1312, 1312, 1312}, 1'b0);
        stop_meas();

        // Glitches must not disturb the measurement
        start_meas();
        run_seq('{2624, 2624, 2624, 2624}, '{1312, 1312, 1312, 1312}, 1'b1);
        stop_meas();

        // Randomized runs, several back-to-back results without re-arm
        rand_seq(12, 24, 300, 8, ps, hs);
        start_meas();
        run_seq(ps, hs, 1'b0);
        stop_meas();
        rand_seq(8, 30, 300, 10, ps, hs);
        start_meas();
        run_seq(ps, hs, 1'b1);
        stop_meas();

        // Loss of signal after arming, then recovery
        start_meas();
        comp = 1'b1; cyc(20); comp = 1'b0;
        cyc(TMO + 100);
        check("tmo_set", tmo, 1);
        check("tmo_no_valid", mif.meas_valid, 0);
        rand_seq(4, 24, 300, 8, ps, hs);
        run_seq(ps, hs, 1'b0);
        check("tmo_cleared", tmo, 0);
        stop_meas();

        // en dropped mid-period: partial data discarded, fresh arm needed
        start_meas();
        drive_per(200, 90, 1'b0);
        drive_per(150, 70, 1'b0);
        comp = 1'b1; cyc(10);
        en = 1'b0; cyc(100);
        en = 1'b1; cyc(10);
        comp = 1'b0; cyc(20);
        rand_seq(4, 24, 300, 8, ps, hs);
        run_seq(ps, hs, 1'b0);
        stop_meas();

        // Ready coincident with completion, then overwrite of an unread result
        ready = 1'b0;
        rand_seq(12, 60, 300, 20, ps, hs);
        eb = avg(ps, hs, 4);
        ec = avg(ps, hs, 8);
        start_meas();
        for (int j = 0; j < 8; j++) begin
            if (j == 4) exp_q.push_back(avg(ps, hs, 0));
            drive_per(ps[j], hs[j], 1'b0);
        end
        fork
            begin
                cyc(5); ready = 1'b1;
                cyc(1); ready = 1'b0;
            end
        join_none
        comp = 1'b1; cyc(10);
        check("coinc_valid", mif.meas_valid, 1);
        check("coinc_overrun", ovr, 0);
        check("coinc_period", mif.period, eb.per);
        check("coinc_high", mif.high_time, eb.hi);
        cyc(hs[8] - 10); comp = 1'b0; cyc(ps[8] - hs[8]);
        for (int j = 9; j < 12; j++) drive_per(ps[j], hs[j], 1'b0);
        comp = 1'b1; cyc(10);
        check("ovr_valid", mif.meas_valid, 1);
        check("ovr_set", ovr, 1);
        check("ovr_period", mif.period, ec.per);
        check("ovr_high", mif.high_time, ec.hi);
        exp_q.push_back(ec);
        ready = 1'b1; cyc(1);
        ready = 1'b0; cyc(1);
        check("ready_drop_valid", mif.meas_valid, 0);
        check("ovr_sticky", ovr, 1);

        // Reset in the middle of a measurement
        nrst = 1'b1; cyc(1);
        check("mid_rst_valid", mif.meas_valid, 0);
        check("mid_rst_period", mif.period, 0);
        check("mid_rst_high", mif.high_time, 0);
        check("mid_rst_timeout", tmo, 0);
        check("mid_rst_overrun", ovr, 0);
        nrst = 1'b0;
        en = 1'b0; comp = 1'b0; ready = 1'b1;
        cyc(20);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
